// File: rtl/be_to_le_word_assembler.sv
// be_to_le_word_assembler: packs a big-endian byte stream into little-endian lane-ordered words.
module be_to_le_word_assembler #(
  parameter int DATA_W = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  byte_valid_i,
  output logic                                  byte_ready_o,
  input  logic [7:0]                            byte_data_i,
  input  logic                                  byte_last_i,
  output logic                                  word_valid_o,
  input  logic                                  word_ready_i,
  output logic [DATA_W-1:0]                     le_data_o,
  output logic [$clog2(DATA_W/8):0]             word_bytes_o
);
  localparam int NUM_BYTES = DATA_W / 8;
  localparam int IDX_W = $clog2(NUM_BYTES);
  localparam int CNT_W = IDX_W + 1;
  if (DATA_W % 8 != 0 || DATA_W < 16) begin : g_bad_width
    $fatal(1, "DATA_W must be a multiple of 8 and at least 16");
  end
  logic [DATA_W-1:0] acc_q, acc_d, merged, data_q, data_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  bytes_q, bytes_d;
  logic              valid_q, valid_d;
  logic              accept, close;
  assign byte_ready_o = reset && !(valid_q && !word_ready_i);
  assign accept       = byte_valid_i && byte_ready_o;
  assign close        = accept && (cnt_q == IDX_W'(NUM_BYTES - 1) || byte_last_i);
  // acc only ever holds lanes below cnt, so the merged word already has zeroed upper lanes
  always_comb begin
    merged = acc_q;
    for (int i = 0; i < NUM_BYTES; i++)
      if (cnt_q == IDX_W'(i)) merged[8*i +: 8] = byte_data_i;
  end
  always_comb begin
    acc_d   = close ? '0 : accept ? merged : acc_q;
    cnt_d   = close ? '0 : accept ? cnt_q + IDX_W'(1) : cnt_q;
    data_d  = close ? merged : data_q;
    bytes_d = close ? CNT_W'(cnt_q) + CNT_W'(1) : bytes_q;
    valid_d = close || (valid_q && !word_ready_i);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      bytes_q <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      bytes_q <= bytes_d;
      valid_q <= valid_d;
    end
  end
  assign word_valid_o = valid_q;
  assign le_data_o    = data_q;
  assign word_bytes_o = bytes_q;
endmodule

// File: tb/tb_be_to_le_word_assembler.sv
// tb_be_to_le_word_assembler: directed vector table plus hand sequences for stalls and reset.
module tb_be_to_le_word_assembler;
  logic        clk = 0;
  logic        reset;
  logic        byte_valid_i, byte_last_i, word_ready_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o, word_valid_o;
  logic [31:0] le_data_o;
  logic [2:0]  word_bytes_o;
  int          tests = 0, fails = 0;

  be_to_le_word_assembler #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
    .byte_data_i(byte_data_i), .byte_last_i(byte_last_i),
    .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
    .le_data_o(le_data_o), .word_bytes_o(word_bytes_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, last, wr;
    logic [7:0]  d;
    logic        ev, ebr;
    logic [31:0] ed;
    int          eb;
  } vec_t;
  vec_t vec[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic last, input logic [7:0] d, input logic wr);
    byte_valid_i = v; byte_last_i = last; byte_data_i = d; word_ready_i = wr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string name, input logic [31:0] ed, input int eb);
    chk({name, "_valid"}, {31'b0, word_valid_o}, 32'd1);
    chk({name, "_data"}, le_data_o, ed);
    chk({name, "_bytes"}, {29'b0, word_bytes_o}, eb[31:0]);
  endtask

  initial begin
    vec[0]  = '{1, 0, 1, 8'h12, 0, 1, 0, 0};
    vec[1]  = '{1, 0, 1, 8'h34, 0, 1, 0, 0};
    vec[2]  = '{1, 0, 1, 8'h56, 0, 1, 0, 0};
    vec[3]  = '{1, 0, 1, 8'h78, 0, 1, 0, 0};
    vec[4]  = '{1, 0, 1, 8'hAA, 1, 1, 32'h78563412, 4};
    vec[5]  = '{1, 1, 1, 8'hBB, 0, 1, 0, 0};
    vec[6]  = '{1, 1, 1, 8'h01, 1, 1, 32'h0000BBAA, 2};
    vec[7]  = '{0, 1, 1, 8'hFF, 1, 1, 32'h00000001, 1};
    vec[8]  = '{1, 0, 1, 8'h00, 0, 1, 0, 0};
    vec[9]  = '{1, 0, 1, 8'h01, 0, 1, 0, 0};
    vec[10] = '{1, 0, 1, 8'h02, 0, 1, 0, 0};
    vec[11] = '{1, 0, 1, 8'h03, 0, 1, 0, 0};
    vec[12] = '{1, 0, 1, 8'h04, 1, 1, 32'h03020100, 4};
    vec[13] = '{1, 0, 1, 8'h05, 0, 1, 0, 0};
    vec[14] = '{1, 0, 1, 8'h06, 0, 1, 0, 0};
    vec[15] = '{1, 0, 1, 8'h07, 0, 1, 0, 0};
    vec[16] = '{0, 0, 1, 8'h00, 1, 1, 32'h07060504, 4};
    vec[17] = '{0, 0, 1, 8'h00, 0, 1, 0, 0};

    reset = 0;
    drive(1, 0, 8'h5A, 1);
    tick(); tick();
    chk("rst_valid", {31'b0, word_valid_o}, 0);
    chk("rst_data", le_data_o, 0);
    chk("rst_bytes", {29'b0, word_bytes_o}, 0);
    chk("rst_ready", {31'b0, byte_ready_o}, 0);
    reset = 1;

    for (int i = 0; i < 18; i++) begin
      drive(vec[i].v, vec[i].last, vec[i].d, vec[i].wr);
      chk($sformatf("v%0d_valid", i), {31'b0, word_valid_o}, {31'b0, vec[i].ev});
      chk($sformatf("v%0d_ready", i), {31'b0, byte_ready_o}, {31'b0, vec[i].ebr});
      if (vec[i].ev) begin
        chk($sformatf("v%0d_data", i), le_data_o, vec[i].ed);
        chk($sformatf("v%0d_bytes", i), {29'b0, word_bytes_o}, vec[i].eb[31:0]);
      end
      tick();
    end

    // Backpressure: word held, ingress stalled, stalled byte must not be taken
    drive(1, 0, 8'hDE, 0); tick();
    drive(1, 0, 8'hAD, 0); tick();
    drive(1, 0, 8'hBE, 0); tick();
    drive(1, 0, 8'hEF, 0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 8'h99, 0);
      chk_word($sformatf("bp%0d", i), 32'hEFBEADDE, 4);
      chk($sformatf("bp%0d_ready", i), {31'b0, byte_ready_o}, 0);
      tick();
    end
    drive(0, 0, 8'h00, 1);
    chk_word("bp_release", 32'hEFBEADDE, 4);
    tick();
    chk("bp_after_valid", {31'b0, word_valid_o}, 0);
    chk("bp_after_ready", {31'b0, byte_ready_o}, 1);
    drive(1, 0, 8'h01, 1); tick();
    drive(1, 0, 8'h02, 1); tick();
    drive(1, 0, 8'h03, 1); tick();
    drive(1, 0, 8'h04, 1); tick();
    drive(0, 0, 8'h00, 1);
    chk_word("bp_next", 32'h04030201, 4);
    tick();

    // Reset mid-word with a stale word still in the output register
    drive(1, 1, 8'h7E, 0); tick();
    drive(1, 0, 8'h11, 0);
    chk_word("pre_rst", 32'h0000007E, 1);
    drive(0, 0, 8'h00, 1); tick();
    drive(1, 0, 8'h11, 1); tick();
    drive(1, 0, 8'h22, 1); tick();
    reset = 0;
    drive(0, 0, 8'h00, 1); tick();
    chk("mrst_valid", {31'b0, word_valid_o}, 0);
    chk("mrst_data", le_data_o, 0);
    chk("mrst_bytes", {29'b0, word_bytes_o}, 0);
    chk("mrst_ready", {31'b0, byte_ready_o}, 0);
    reset = 1;
    drive(1, 0, 8'h33, 1); tick();
    drive(1, 0, 8'h44, 1); tick();
    drive(1, 0, 8'h55, 1); tick();
    drive(1, 0, 8'h66, 1);
    chk("mrst_nowrd", {31'b0, word_valid_o}, 0);
    tick();
    drive(0, 0, 8'h00, 1);
    chk_word("mrst_word", 32'h66554433, 4);
    tick();
    chk("mrst_end", {31'b0, word_valid_o}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
